// File: rtl/aes_iter_decrypt.sv
// Iterative AES-128/192/256 inverse cipher: one round per clock behind valid/ready handshakes.
// Define AES_DEC_KEY_CACHE_EN to keep the key across blocks and reload it only via key_load.
module aes_iter_decrypt #(
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = Nk + 6
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef AES_DEC_KEY_CACHE_EN
  input  logic             key_load,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     data_in,
  input  logic [Nk*32-1:0] key_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     data_out,
  output logic             busy
);
  localparam int unsigned NumWords = 4 * (Nr + 1);
  localparam int unsigned RcntW    = $clog2(Nr + 1);

  if (Nr != Nk + 6) begin : gNrCheck
    $error("aes_iter_decrypt: Nr must equal Nk+6");
  end
  if (Nk != 4 && Nk != 6 && Nk != 8) begin : gNkCheck
    $error("aes_iter_decrypt: Nk must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {StIdle, StRound, StDone} fsmState_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gfInv(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] r;
    t = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      t = gfMul(t, t);
      r = gfMul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = gfInv(x);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] x);
    return gfInv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // keyExpansion: rk[j] holds schedule words 4j..4j+3, first word in the MSBs.
  function automatic logic [Nr:0][127:0] expandKey(input logic [Nk*32-1:0] key);
    logic [31:0] w [NumWords];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [Nr:0][127:0] rk;
    rc = 8'h01;
    for (int i = 0; i < NumWords; i++) begin
      if (i < Nk) begin
        w[i] = key[(Nk-1-i)*32 +: 32];
      end else begin
        t = w[i-1];
        if (i % Nk == 0) begin
          t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = xtime(rc);
        end else if (Nk > 6 && i % Nk == 4) begin
          t = subWord(t);
        end
        w[i] = w[i-Nk] ^ t;
      end
    end
    for (int j = 0; j <= Nr; j++) rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return rk;
  endfunction

  function automatic logic [127:0] lastRoundKey(input logic [Nk*32-1:0] key);
    logic [Nr:0][127:0] rk;
    rk = expandKey(key);
    return rk[Nr];
  endfunction

  // InvShiftRows and InvSubBytes commute, so both happen in one byte-wise pass.
  function automatic logic [127:0] invShiftSub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] = invSbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] invMix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09);
      o[119-32*c -: 8] = gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d);
      o[111-32*c -: 8] = gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b);
      o[103-32*c -: 8] = gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e);
    end
    return o;
  endfunction

  fsmState_e          fsm;
  logic               inReadyQ, outValidQ, busyQ;
  logic [127:0]       stateReg;
  logic [Nk*32-1:0]   keyReg;
  logic [RcntW-1:0]   rcnt;
  logic [Nk*32-1:0]   initKey;
  logic [Nr:0][127:0] rkAll;
  logic [127:0]       rkInit, rkSel, invSR, roundOut;

`ifdef AES_DEC_KEY_CACHE_EN
  // A key loaded in the same cycle as the block handshake is used by that block.
  assign initKey = key_load ? key_in : keyReg;
`else
  assign initKey = key_in;
`endif

  always_comb begin
    rkAll  = expandKey(keyReg);
    rkInit = lastRoundKey(initKey);
    rkSel  = '0;
    for (int i = 0; i <= Nr; i++) begin
      if (rcnt == RcntW'(i)) rkSel = rkAll[i];
    end
    invSR    = invShiftSub(stateReg);
    roundOut = invMix(invSR ^ rkSel);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= StIdle;
      inReadyQ  <= 1'b0;
      outValidQ <= 1'b0;
      busyQ     <= 1'b0;
      stateReg  <= '0;
      keyReg    <= '0;
      rcnt      <= '0;
    end else begin
      unique case (fsm)
        StIdle: begin
          inReadyQ <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
          if (key_load && inReadyQ) keyReg <= key_in;
`else
          if (in_valid && inReadyQ) keyReg <= key_in;
`endif
          if (in_valid && inReadyQ) begin
            stateReg <= data_in ^ rkInit;
            rcnt     <= RcntW'(Nr - 1);
            inReadyQ <= 1'b0;
            busyQ    <= 1'b1;
            fsm      <= StRound;
          end
        end
        StRound: begin
          if (rcnt != '0) begin
            stateReg <= roundOut;
            rcnt     <= rcnt - RcntW'(1);
          end else begin
            stateReg  <= invSR ^ rkSel;
            outValidQ <= 1'b1;
            busyQ     <= 1'b0;
            fsm       <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            outValidQ <= 1'b0;
            inReadyQ  <= 1'b1;
            fsm       <= StIdle;
          end
        end
        default: fsm <= StIdle;
      endcase
    end
  end

  assign in_ready  = inReadyQ;
  assign out_valid = outValidQ;
  assign busy      = busyQ;
  assign data_out  = stateReg;

endmodule
